// File: rtl/bcd_scan_counter_if.sv
// rtl/bcd_scan_counter_if.sv - button inputs and display outputs of the BCD scan counter
interface bcd_scan_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic [3:0]            button;
  logic [NUM_DIGITS-1:0] anode;
  logic [6:0]            seg;
  logic                  tick;
  logic                  rollover;

  modport master (input button, output anode, seg, tick, rollover);
  modport slave  (output button, input anode, seg, tick, rollover);
endinterface

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - debounced multi-digit BCD up/down counter with multiplexed 7-segment scan
module bcd_scan_counter #(
  parameter int NUM_DIGITS      = 4,
  parameter int COUNT_DELAY     = 25000000,
  parameter int SCAN_DELAY      = 625,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLANK_LEADING   = 0
) (
  input  logic               clck,
  input  logic               rst_n,
  bcd_scan_counter_if.master bus
);
  localparam int PW = $clog2(COUNT_DELAY);
  localparam int SW = $clog2(SCAN_DELAY);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST  = PW'(COUNT_DELAY - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DELAY - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [3:0]          sync1, sync2, level, level_q, press;
  logic [3:0][DW-1:0]  db_cnt;

  logic                running, count_up;
  logic [PW-1:0]       presc;
  logic [NUM_DIGITS-1:0][3:0] digits, digits_nx;
  logic                ripple, clear, pre_wrap, step_ev, update;

  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       idx;
  logic [NUM_DIGITS-1:0] blank;
  logic                all_zero;
  logic [3:0]          cur_digit;
  logic [6:0]          pattern;

  // Each bit must disagree with its debounced level for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clck) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      db_cnt  <= '0;
    end else begin
      sync1   <= bus.button;
      sync2   <= sync1;
      level_q <= level;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press    = level & ~level_q;
  assign clear    = press[1];
  assign pre_wrap = running && (presc == PRE_LAST);
  assign step_ev  = press[3] && !running;
  assign update   = (pre_wrap || step_ev) && !clear;

  always_comb begin
    digits_nx = digits;
    ripple    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ripple) begin
        if (count_up) begin
          if (digits[i] == 4'd9) digits_nx[i] = 4'd0;
          else begin
            digits_nx[i] = digits[i] + 4'd1;
            ripple       = 1'b0;
          end
        end else begin
          if (digits[i] == 4'd0) digits_nx[i] = 4'd9;
          else begin
            digits_nx[i] = digits[i] - 4'd1;
            ripple       = 1'b0;
          end
        end
      end
    end
  end

  // Toggles apply after the update decision, so a same-cycle update sees the old mode.
  always_ff @(posedge clck) begin
    if (!rst_n) begin
      digits       <= '0;
      presc        <= '0;
      running      <= 1'b1;
      count_up     <= 1'b1;
      bus.tick     <= 1'b0;
      bus.rollover <= 1'b0;
    end else begin
      bus.tick     <= update;
      bus.rollover <= update && ripple;
      if (clear) begin
        digits <= '0;
        presc  <= '0;
      end else begin
        if (update) digits <= digits_nx;
        if (running) presc <= pre_wrap ? '0 : presc + PW'(1);
      end
      running  <= running ^ press[0];
      count_up <= count_up ^ press[2];
    end
  end

  always_ff @(posedge clck) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_comb begin
    blank    = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (digits[i] == 4'd0);
      blank[i] = all_zero && (i != 0) && (BLANK_LEADING != 0);
    end
  end

  assign cur_digit = digits[idx];

  always_comb begin
    pattern = 7'h00;
    case (cur_digit)
      4'd0: pattern = 7'h7E;
      4'd1: pattern = 7'h30;
      4'd2: pattern = 7'h6D;
      4'd3: pattern = 7'h79;
      4'd4: pattern = 7'h33;
      4'd5: pattern = 7'h5B;
      4'd6: pattern = 7'h5F;
      4'd7: pattern = 7'h70;
      4'd8: pattern = 7'h7F;
      4'd9: pattern = 7'h7B;
      default: pattern = 7'h00;
    endcase
  end

  always_ff @(posedge clck) begin
    if (!rst_n) begin
      bus.anode <= '1;
      bus.seg   <= 7'h7F;
    end else begin
      bus.anode <= ~(NUM_DIGITS'(1) << idx);
      bus.seg   <= blank[idx] ? 7'h7F : ~pattern;
    end
  end
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - directed self-checking bench for bcd_scan_counter
module tb_bcd_scan_counter;
  localparam int ND = 2;
  localparam int CD = 4;
  localparam int SD = 2;
  localparam int DB = 3;
  localparam int PRESS_LAT = 6;

  logic       clck = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  int         checks = 0;
  int         failures = 0;

  always #5 clck = ~clck;

  bcd_scan_counter_if #(.NUM_DIGITS(ND)) bus_a ();
  bcd_scan_counter_if #(.NUM_DIGITS(ND)) bus_b ();
  assign bus_a.button = btn;
  assign bus_b.button = btn;

  bcd_scan_counter #(.NUM_DIGITS(ND), .COUNT_DELAY(CD), .SCAN_DELAY(SD),
                     .DEBOUNCE_CYCLES(DB), .BLANK_LEADING(0))
    dut_a (.clck(clck), .rst_n(rst_n), .bus(bus_a));
  bcd_scan_counter #(.NUM_DIGITS(ND), .COUNT_DELAY(CD), .SCAN_DELAY(SD),
                     .DEBOUNCE_CYCLES(DB), .BLANK_LEADING(1))
    dut_b (.clck(clck), .rst_n(rst_n), .bus(bus_b));

  logic [21:0] obs;
  logic [21:0] expv;
  assign obs = {bus_a.tick, bus_a.rollover, bus_a.anode, bus_a.seg,
                bus_b.tick, bus_b.rollover, bus_b.anode, bus_b.seg};

  int cyc, mcount, mpre, sc, sidx;
  bit mup, mrun;
  int ev_cyc [4];

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h7E; 1: return 7'h30; 2: return 7'h6D; 3: return 7'h79;
      4: return 7'h33; 5: return 7'h5B; 6: return 7'h5F; 7: return 7'h70;
      8: return 7'h7F; 9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int dec(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (~pat(d) === s) return d;
    return -100;
  endfunction

  function automatic logic [6:0] seg_of(input int count, input int digit, input bit blank);
    if (blank && digit == 1 && count / 10 == 0) return 7'h7F;
    return ~pat(digit == 1 ? count / 10 : count % 10);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    btn   = 4'b0;
    @(posedge clck); #1;
    cyc = 0; mcount = 0; mpre = 0; sc = 0; sidx = 0; mup = 1; mrun = 1;
    for (int i = 0; i < 4; i++) ev_cyc[i] = -1;
    rst_n = 1'b1;
  endtask

  // Advances one clock and predicts the outputs registered at that edge.
  task automatic clk_step();
    logic [3:0] p;
    logic [1:0] an;
    bit pre_t, stp, upd, wrp;
    for (int i = 0; i < 4; i++) p[i] = (ev_cyc[i] == cyc + 1);
    an    = (sidx == 0) ? 2'b10 : 2'b01;
    pre_t = mrun && (mpre == CD - 1);
    stp   = p[3] && !mrun;
    upd   = (pre_t || stp) && !p[1];
    wrp   = mup ? (mcount == 99) : (mcount == 0);
    expv  = {upd, upd && wrp, an, seg_of(mcount, sidx, 0),
             upd, upd && wrp, an, seg_of(mcount, sidx, 1)};
    if (p[1]) begin
      mcount = 0;
      mpre   = 0;
    end else begin
      if (upd) mcount = mup ? (mcount + 1) % 100 : (mcount + 99) % 100;
      if (mrun) mpre = pre_t ? 0 : mpre + 1;
    end
    if (p[0]) mrun = !mrun;
    if (p[2]) mup = !mup;
    if (sc == SD - 1) begin
      sc   = 0;
      sidx = 1 - sidx;
    end else sc++;
    @(posedge clck); #1;
    cyc++;
  endtask

  task automatic press(input int b, input int hold);
    btn[b]    = 1'b1;
    ev_cyc[b] = (hold >= DB) ? cyc + PRESS_LAT : -1;
    repeat (hold) clk_step();
    btn[b] = 1'b0;
  endtask

  task automatic read_disp(output int cnt, output logic [6:0] s0a, output logic [6:0] s1a,
                           output logic [6:0] s0b, output logic [6:0] s1b);
    s0a = 'x; s1a = 'x; s0b = 'x; s1b = 'x;
    repeat (4) begin
      clk_step();
      if (bus_a.anode === 2'b10) s0a = bus_a.seg;
      if (bus_a.anode === 2'b01) s1a = bus_a.seg;
      if (bus_b.anode === 2'b10) s0b = bus_b.seg;
      if (bus_b.anode === 2'b01) s1b = bus_b.seg;
    end
    cnt = 10 * dec(s1a) + dec(s0a);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== {2'b00, 2'b11, 7'h7F, 2'b00, 2'b11, 7'h7F}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs, {2'b00, 2'b11, 7'h7F, 2'b00, 2'b11, 7'h7F});
    end
  endtask

  task automatic test_count_scan();
    int cnt;
    logic [6:0] s0a, s1a, s0b, s1b;
    while (cyc < 40) begin
      clk_step();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL count_scan cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    read_disp(cnt, s0a, s1a, s0b, s1b);
    checks++;
    if (cnt !== 10) begin failures++; $display("FAIL count_after_40 got=%0d exp=10", cnt); end
    checks++;
    if (s1a !== 7'h4F) begin failures++; $display("FAIL seg_digit1 got=%h exp=4f", s1a); end
  endtask

  task automatic test_rollover();
    int cnt;
    logic [6:0] s0a, s1a, s0b, s1b;
    while (cyc < 404) begin
      if (cyc == 396) press(2, 3);
      clk_step();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL rollover_run cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (cyc == 400 || cyc == 404) begin
        checks++;
        if ({bus_a.tick, bus_a.rollover} !== 2'b11) begin
          failures++;
          $display("FAIL rollover_pulse cyc=%0d got=%b exp=11", cyc, {bus_a.tick, bus_a.rollover});
        end
      end
      if (cyc == 401) begin
        checks++;
        if (bus_a.rollover !== 1'b0) begin failures++; $display("FAIL rollover_width got=%b exp=0", bus_a.rollover); end
      end
    end
    read_disp(cnt, s0a, s1a, s0b, s1b);
    checks++;
    if (cnt !== 99) begin failures++; $display("FAIL down_wrap got=%0d exp=99", cnt); end
  endtask

  task automatic test_debounce_clear();
    int cnt;
    logic [6:0] s0a, s1a, s0b, s1b;
    press(1, 2);
    repeat (10) begin
      clk_step();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    press(1, 4);
    while (cyc < 426) begin
      clk_step();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL clear_run cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    checks++;
    if (bus_a.tick !== 1'b0) begin failures++; $display("FAIL clear_no_tick got=%b exp=0", bus_a.tick); end
    read_disp(cnt, s0a, s1a, s0b, s1b);
    checks++;
    if (cnt !== 0) begin failures++; $display("FAIL clear_value got=%0d exp=0", cnt); end
    repeat (10) begin
      clk_step();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL after_clear cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
  endtask

  task automatic test_pause_step();
    int cnt;
    logic [6:0] s0a, s1a, s0b, s1b;
    do_reset();
    press(0, 3);
    while (cyc < 30) begin
      clk_step();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL pause cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    read_disp(cnt, s0a, s1a, s0b, s1b);
    checks++;
    if (cnt !== 1) begin failures++; $display("FAIL paused_value got=%0d exp=1", cnt); end
    while (cyc < 56) begin
      if (cyc == 34 || cyc == 45) press(3, 3);
      else begin
        clk_step();
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL step cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      end
    end
    read_disp(cnt, s0a, s1a, s0b, s1b);
    checks++;
    if (cnt !== 3) begin failures++; $display("FAIL step_value got=%0d exp=3", cnt); end
    while (cyc < 84) begin
      if (cyc == 60) press(0, 3);
      else if (cyc == 70) press(3, 3);
      else begin
        clk_step();
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL step_running cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      end
    end
  endtask

  task automatic test_same_cycle();
    int cnt;
    logic [6:0] s0a, s1a, s0b, s1b;
    do_reset();
    while (cyc < 16) begin
      if (cyc == 10) press(1, 3);
      else begin
        clk_step();
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL clear_wrap cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      end
    end
    checks++;
    if (bus_a.tick !== 1'b0) begin failures++; $display("FAIL clear_wrap_tick got=%b exp=0", bus_a.tick); end
    read_disp(cnt, s0a, s1a, s0b, s1b);
    checks++;
    if (cnt !== 0) begin failures++; $display("FAIL clear_wrap_value got=%0d exp=0", cnt); end
    while (cyc < 28) begin
      if (cyc == 22) press(2, 3);
      else begin
        clk_step();
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL dir_tick cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      end
    end
    checks++;
    if (bus_a.tick !== 1'b1) begin failures++; $display("FAIL dir_tick_pulse got=%b exp=1", bus_a.tick); end
    read_disp(cnt, s0a, s1a, s0b, s1b);
    checks++;
    if (cnt !== 3) begin failures++; $display("FAIL dir_old_direction got=%0d exp=3", cnt); end
    while (cyc < 40) begin
      clk_step();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL dir_after cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
  endtask

  task automatic test_blank_reset();
    int cnt;
    logic [6:0] s0a, s1a, s0b, s1b;
    do_reset();
    read_disp(cnt, s0a, s1a, s0b, s1b);
    checks++;
    if ({s1b, s0b} !== {7'h7F, 7'h01}) begin
      failures++;
      $display("FAIL blank_zero got=%h exp=%h", {s1b, s0b}, {7'h7F, 7'h01});
    end
    while (cyc < 20) begin
      clk_step();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL blank_run cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    read_disp(cnt, s0a, s1a, s0b, s1b);
    checks++;
    if ({s1b, s0b} !== {7'h7F, 7'h24}) begin
      failures++;
      $display("FAIL blank_five got=%h exp=%h", {s1b, s0b}, {7'h7F, 7'h24});
    end
    checks++;
    if (cnt !== 5) begin failures++; $display("FAIL unblanked_five got=%0d exp=5", cnt); end
    repeat (3) clk_step();
    do_reset();
    checks++;
    if (obs !== {2'b00, 2'b11, 7'h7F, 2'b00, 2'b11, 7'h7F}) begin
      failures++;
      $display("FAIL midrun_reset got=%h exp=%h", obs, {2'b00, 2'b11, 7'h7F, 2'b00, 2'b11, 7'h7F});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 4'b0;
    test_reset();
    test_count_scan();
    test_rollover();
    test_debounce_clear();
    test_pause_step();
    test_same_cycle();
    test_blank_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
Parametrised multi-digit BCD up/down counter driving a time-multiplexed, common-anode 7-segment display. It adds button control (run/pause, clear, direction, single-step), input debouncing, a rollover flag and optional leading-zero blanking. It sits directly between the board clock and buttons and the anode/segment pins.

Parameters:
NUM_DIGITS, 4, number of BCD digits and anode lines (2..8)
COUNT_DELAY, 25000000, clck cycles per count tick (>=2)
SCAN_DELAY, 625, clck cycles each digit stays lit (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a new button level (>=2)
BLANK_LEADING, 0, 1 = blank leading zero digits

Ports:
clck  in  1  system clock
rst_n  in  1  synchronous active-low reset
button  in  4  raw async buttons, active-high: [0] run/pause toggle, [1] clear, [2] direction toggle, [3] single step
anode  out  NUM_DIGITS  digit enables, active-low; anode[0] = least significant digit
seg  out  7  segments, active-low; seg[6]=A ... seg[0]=G
tick  out  1  one-cycle pulse on every count update, including step; not asserted on clear
rollover  out  1  one-cycle pulse on full-count wrap

Behaviour:
- Reset (rst_n=0 at clck edge): all digits 0, running=1, direction=up, prescaler=0, scan index=0, debounced levels=0, anode=all 1, seg=7'h7F, tick=0, rollover=0. Applies mid-operation; debounce state also clears.
- Buttons: 2-flop synchroniser per bit. Debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count. Press event = debounced 0->1, one-cycle pulse. Releases have no effect.
- Prescaler: while running, counts 0..COUNT_DELAY-1. At COUNT_DELAY-1 it wraps to 0 and issues an internal tick, so the period is exactly COUNT_DELAY cycles. While paused it holds its value.
- Count update on tick or step: ripple BCD across all digits in one cycle.
  - Up: 9->0 with carry.
  - Down: 0->9 with borrow.
  - All-9 up -> all-0, and all-0 down -> all-9, each with rollover=1.
  - tick/rollover are registered and coincide with the count register update.
- Step (press on button[3]) acts only when paused. Ignored while running.
- Per-cycle priority: clear > count update > pause/direction toggles.
  - Clear sets digits=0 and prescaler=0 and suppresses any same-cycle tick.
  - Direction toggle in the same cycle as an update: the update uses the old direction.
  - Run/pause toggle in the same cycle as a prescaler wrap: that tick still counts.
- Scan: a separate counter runs 0..SCAN_DELAY-1 and advances the index 0..NUM_DIGITS-1, wrapping. It runs regardless of pause state.
- Outputs: anode and seg are registered with 1-cycle latency from index/digit change. anode has exactly one bit low, bit = index. seg = ~pattern.
- Patterns: 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B.
- BLANK_LEADING=1: digit i>0 shows seg=7'h7F when it and all higher digits are 0. Digit 0 is never blanked.
- Digit values never leave 0..9. No other illegal states exist.

Test Plan:
(Params for all: NUM_DIGITS=2, COUNT_DELAY=4, SCAN_DELAY=2, DEBOUNCE_CYCLES=3.)
1. Reset then run 40 cycles -> tick every 4 cycles; count 00->0A impossible, reads 10 after 40 cycles. anode alternates 2'b10/2'b01 every 2 cycles. seg for digit1=1 is ~7'h30=7'h4F.
2. Run to 99, next tick -> count 00, rollover=1 for exactly one cycle with tick. Toggle direction, next tick -> 99 with rollover.
3. Button[1] pulse 2 cycles (bounce) -> no clear. Held 3+ cycles -> clear exactly once after sync+debounce delay (~5 cycles), count 00, no tick.
4. Pause via button[0], wait 20 cycles -> count frozen, no tick. Press button[3] twice -> two ticks, +2. Press button[3] while running -> no extra count.
5. Clear press in same cycle as prescaler wrap -> count 00, tick=0. Direction toggle in same cycle as tick -> that update uses old direction.
6. BLANK_LEADING=1, count 05 -> digit1 seg=7'h7F, digit0 seg=~7'h5B. Count 00 -> digit0 shows 0. Assert rst_n=0 mid-run -> next edge all outputs at reset values.
